// File: rtl/fewcore_pkg.sv
// fewcore_pkg: shared encodings for the fewcore pipeline control block.
//   state_e      - controller states as exposed on pipeline_ctrl.state
//   FWD_*        - operand-source encodings driven on fwd1/fwd2
//   FCNT_W       - width of the flush down-counter (FLUSH_LEN is 1..7)
package fewcore_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;  // register file
  localparam logic [1:0] FWD_EX = 2'b01;  // execute-stage result
  localparam logic [1:0] FWD_WB = 2'b10;  // write-stage data

  localparam int FCNT_W = 3;

endpackage

// File: rtl/fwd_select.sv
// fwd_select: per-operand forwarding and load-use detection.
//   id_rs, id_use          - source register of the decode instruction, and whether it is read
//   ex_rd, ex_we, ex_is_load - execute-stage destination info
//   wb_rd, wb_we           - write-stage destination info
//   fwd                    - operand source (FWD_RF / FWD_EX / FWD_WB), execute wins
//   load_hit               - operand is read and depends on a load still in execute
module fwd_select
  import fewcore_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic [RW-1:0] id_rs,
  input  logic          id_use,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_we,
  input  logic          ex_is_load,
  input  logic [RW-1:0] wb_rd,
  input  logic          wb_we,
  output logic [1:0]    fwd,
  output logic          load_hit
);

  logic rs_nz;
  logic ex_match;
  logic wb_match;

  // Register 0 is hard-wired zero, so it never creates a dependency.
  assign rs_nz    = (id_rs != '0);
  assign ex_match = rs_nz && ex_we && (id_rs == ex_rd);
  assign wb_match = rs_nz && wb_we && (id_rs == wb_rd);

  // A load's data is not available in execute, so it can never be forwarded from there.
  always_comb begin
    fwd = FWD_RF;
    if (ex_match && !ex_is_load) begin
      fwd = FWD_EX;
    end else if (wb_match) begin
      fwd = FWD_WB;
    end
  end

  assign load_hit = id_use && ex_match && ex_is_load;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, forwarding, flush and halt control for a short in-order pipeline.
//   clk, reset (async, active-low)
//   id_rs1/id_rs2, id_use1/id_use2       - decode-stage sources
//   ex_rd, ex_we, ex_is_load, wb_rd, wb_we - downstream destinations
//   br_taken, halt_req, resume           - control events (single-cycle pulses)
//   pc_stall, id_stall, ex_bubble, flush - pipeline steering, combinational
//   fwd1, fwd2                           - operand sources, combinational
//   halted, state                        - controller status
//   stall_cnt, flush_cnt                 - saturating event counters
// Handshake: there is no valid/ready pair here; every input is sampled each cycle and
// every steering output is valid in the same cycle as the inputs that caused it.
module pipeline_ctrl
  import fewcore_pkg::*;
#(
  parameter int RW        = 5,
  parameter int FLUSH_LEN = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RW-1:0]    id_rs1,
  input  logic [RW-1:0]    id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [RW-1:0]    ex_rd,
  input  logic             ex_we,
  input  logic             ex_is_load,
  input  logic [RW-1:0]    wb_rd,
  input  logic             wb_we,
  input  logic             br_taken,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_stall,
  output logic             id_stall,
  output logic             ex_bubble,
  output logic             flush,
  output logic [1:0]       fwd1,
  output logic [1:0]       fwd2,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [FCNT_W-1:0] FLUSH_INIT = FCNT_W'(FLUSH_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  state_e              state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                drain_q, drain_d;
  logic                pending_q, pending_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

  logic [1:0] fwd1_raw, fwd2_raw;
  logic       hit1, hit2;

  fwd_select #(.RW(RW)) u_fwd1 (
    .id_rs(id_rs1), .id_use(id_use1), .ex_rd(ex_rd), .ex_we(ex_we),
    .ex_is_load(ex_is_load), .wb_rd(wb_rd), .wb_we(wb_we),
    .fwd(fwd1_raw), .load_hit(hit1)
  );

  fwd_select #(.RW(RW)) u_fwd2 (
    .id_rs(id_rs2), .id_use(id_use2), .ex_rd(ex_rd), .ex_we(ex_we),
    .ex_is_load(ex_is_load), .wb_rd(wb_rd), .wb_we(wb_we),
    .fwd(fwd2_raw), .load_hit(hit2)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      fcnt_q      <= '0;
      drain_q     <= 1'b0;
      pending_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      drain_q     <= drain_d;
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    drain_d     = drain_q;
    pending_d   = pending_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pc_stall    = 1'b0;
    id_stall    = 1'b0;
    ex_bubble   = 1'b0;
    flush       = 1'b0;
    halted      = 1'b0;
    fwd1        = fwd1_raw;
    fwd2        = fwd2_raw;

    // A halt request is remembered until the controller actually reaches HALT and resumes.
    if (halt_req && (state_q != ST_HALT)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        if (br_taken) begin
          // The branch squashes the dependent instruction, so no load-use stall is needed.
          flush     = 1'b1;
          ex_bubble = 1'b1;
          if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_W'(1);
          if (FLUSH_LEN > 1) begin
            state_d = ST_FLUSH;
            fcnt_d  = FLUSH_INIT;
          end
        end else if (hit1 || hit2) begin
          pc_stall  = 1'b1;
          id_stall  = 1'b1;
          ex_bubble = 1'b1;
          if (hit1) fwd1 = FWD_RF;
          if (hit2) fwd2 = FWD_RF;
          if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else if (pending_q) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end
      end
      ST_FLUSH: begin
        flush     = 1'b1;
        ex_bubble = 1'b1;
        fwd1      = FWD_RF;
        fwd2      = FWD_RF;
        // The RUN cycle that took the branch was the first flush cycle; this counts the rest.
        if (fcnt_q <= FCNT_W'(1)) state_d = ST_RUN;
        if (fcnt_q != '0) fcnt_d = fcnt_q - FCNT_W'(1);
      end
      ST_DRAIN: begin
        // Front end frozen while the back end empties; execute keeps flowing.
        pc_stall = 1'b1;
        id_stall = 1'b1;
        drain_d  = 1'b1;
        if (drain_q) state_d = ST_HALT;
      end
      ST_HALT: begin
        pc_stall  = 1'b1;
        id_stall  = 1'b1;
        ex_bubble = 1'b1;
        halted    = 1'b1;
        if (resume) begin
          state_d   = ST_RUN;
          pending_d = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter RW, default 5: register-index width.
REQ-002 SHALL have parameter FLUSH_LEN, default 2: cycles of flush per taken branch (1..7).
REQ-003 SHALL have parameter CNT_W, default 16: event counter width.
REQ-004 SHALL have port clk  in  1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1: asynchronous, active-low reset.
REQ-006 SHALL have ports id_rs1, id_rs2  in  RW: source registers of the instruction in fetch/decode.
REQ-007 SHALL have ports id_use1, id_use2  in  1: the decode instruction actually reads rs1 / rs2.
REQ-008 SHALL have ports ex_rd in RW, ex_we in 1, ex_is_load in 1: destination, write-enable and load flag of the instruction in execute.
REQ-009 SHALL have ports wb_rd in RW, wb_we in 1: destination and write-enable of the instruction in write.
REQ-010 SHALL have port br_taken  in  1: execute resolved a taken branch (new PC valid this cycle).
REQ-011 SHALL have ports halt_req, resume  in  1: single-cycle pulses.
REQ-012 SHALL have ports pc_stall, id_stall, ex_bubble, flush  out  1: hold PC, hold decode register, load NOP into execute, kill fetch/decode.
REQ-013 SHALL have ports fwd1, fwd2  out  2: operand source, 00 register file, 01 execute result, 10 write-stage data.
REQ-014 SHALL have ports halted out 1, state out 2, stall_cnt out CNT_W, flush_cnt out CNT_W.

Function
REQ-015 SHALL implement states RUN=0, FLUSH=1, DRAIN=2, HALT=3, exposed on state.
REQ-016 SHALL compute hazard, forwarding and stall/flush outputs combinationally from state and inputs (zero latency).
REQ-017 SHALL treat register 0 as never hazarding and never forwarded.
REQ-018 SHALL select fwdN=01 when idN matches ex_rd with ex_we=1 and ex_is_load=0; else 10 when it matches wb_rd with wb_we=1; else 00; execute has priority over write.
REQ-019 SHALL, in RUN, flag load-use when ex_is_load=1, ex_we=1 and ex_rd matches a used id source; then pc_stall=id_stall=ex_bubble=1 for exactly that cycle and fwd of the matched operand=00.
REQ-020 SHALL, in RUN with br_taken=1, assert flush=ex_bubble=1 that cycle, suppress any load-use stall, load a down-counter with FLUSH_LEN-1 and go to FLUSH (to RUN directly if FLUSH_LEN=1).
REQ-021 SHALL, in FLUSH, assert flush=ex_bubble=1, fwd1=fwd2=00, ignore br_taken, decrement, and return to RUN when the counter reaches 0.
REQ-022 SHALL latch halt_req into a pending bit in any state except HALT; pending is honoured in RUN only when br_taken=0 and no load-use stall is active.
REQ-023 SHALL, on honouring a pending halt, go to DRAIN for 2 cycles asserting pc_stall=id_stall=1, ex_bubble=0, then HALT.
REQ-024 SHALL, in HALT, assert pc_stall=id_stall=ex_bubble=1 and halted=1; resume returns to RUN next cycle and clears pending; halt_req in HALT is ignored.
REQ-025 SHALL, when br_taken and halt_req coincide, complete FLUSH first, then DRAIN.
REQ-026 SHALL increment stall_cnt per load-use stall cycle and flush_cnt per accepted taken branch, both saturating at all-ones.

Reset
REQ-027 SHALL on reset=0 immediately set state=RUN, counters and pending to 0, halted=0; combinational outputs then follow RUN rules.
REQ-028 SHALL abandon any in-progress FLUSH, DRAIN or HALT when reset asserts mid-operation.

Structure
REQ-029 SHALL take the state encoding and fwd encoding constants from shared package fewcore_pkg.
REQ-030 SHALL put forwarding comparison in sub-module fwd_select, instanced once per operand.

Verification
REQ-031 SHALL check: ex_rd=5, ex_we=1, load=0, id_rs1=5, use1=1 -> fwd1=01, no stall; same with wb only -> fwd1=10.
REQ-032 SHALL check: ex load rd=3, id_rs2=3, use2=1 -> one cycle pc_stall=id_stall=ex_bubble=1, stall_cnt 0->1; id_rs2=0 -> no stall.
REQ-033 SHALL check: br_taken pulse, FLUSH_LEN=2 -> flush high 2 cycles, second br_taken inside ignored, flush_cnt=1.
REQ-034 SHALL check: halt_req with br_taken same cycle -> 2 flush cycles, 2 DRAIN cycles, halted=1; resume -> RUN next cycle.
REQ-035 SHALL check: reset asserted in HALT and mid-FLUSH -> state=0, counters 0, halted=0 asynchronously.
REQ-036 SHALL check: stall_cnt with CNT_W=4 saturates at 15 after 20 load-use stalls.
